// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// The RUN state resolves hazards in this order: memory wait, then taken branch, then load-use.
// MEM_WAIT freezes the whole pipeline until the memory acks.
// ERR is a terminal freeze entered when the memory never answers.
module pipeline_hazard_ctrl #(
  parameter int REGW        = 16,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNTW        = 16
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_uses_rs2,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_memread,
  input  logic            ex_br_taken,
  input  logic            mem_req,
  input  logic            mem_ack,
  output logic            pc_we,
  output logic            ifid_we,
  output logic            ifid_clr,
  output logic            idex_we,
  output logic            idex_clr,
  output logic            exmem_we,
  output logic [CNTW-1:0] stall_count,
  output logic            mem_err
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_nxt;
  logic        err_nxt;
  logic        lu, mw;

  // x0 is hardwired, so a load targeting it can never create a dependency
  assign lu = ex_memread && (ex_rd != '0) &&
              ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  assign mw = mem_req && !mem_ack;

  // State, wait counter and sticky error register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      mem_err  <= err_nxt;
    end
  end

  // Saturating count of cycles in which the PC did not advance
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)
      stall_count <= '0;
    else if (!pc_we && (stall_count != '1))
      stall_count <= stall_count + CNTW'(1);
  end

  // Next state and same-cycle stage enables/clears
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    err_nxt   = mem_err;
    pc_we     = 1'b0;
    ifid_we   = 1'b0;
    ifid_clr  = 1'b0;
    idex_we   = 1'b0;
    idex_clr  = 1'b0;
    exmem_we  = 1'b0;
    case (state)
      RUN: begin
        if (mw) begin
          // full freeze starts this very cycle
          state_nxt = MEM_WAIT;
          wait_nxt  = 16'd1;
        end else if (ex_br_taken) begin
          // squash both wrong-path slots; a pending load-use dies with them
          pc_we    = 1'b1;
          ifid_we  = 1'b1;
          idex_we  = 1'b1;
          exmem_we = 1'b1;
          ifid_clr = 1'b1;
          idex_clr = 1'b1;
        end else if (lu) begin
          // hold PC and IF/ID, push a bubble into ID/EX
          idex_we  = 1'b1;
          idex_clr = 1'b1;
          exmem_we = 1'b1;
        end else begin
          pc_we    = 1'b1;
          ifid_we  = 1'b1;
          idex_we  = 1'b1;
          exmem_we = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          // the ack cycle advances the pipeline like an unhazarded RUN cycle
          pc_we     = 1'b1;
          ifid_we   = 1'b1;
          idex_we   = 1'b1;
          exmem_we  = 1'b1;
          state_nxt = RUN;
          wait_nxt  = '0;
        end else if (wait_cnt == TMO) begin
          err_nxt   = 1'b1;
          state_nxt = ERR;
        end else begin
          wait_nxt  = wait_cnt + 16'd1;
        end
      end
      default: ;  // ERR: frozen until reset
    endcase
    // nothing moves while reset is held
    if (Reset) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      ifid_clr = 1'b0;
      idex_we  = 1'b0;
      idex_clr = 1'b0;
      exmem_we = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a table of single-cycle RUN vectors
// plus hand-written memory-wait, timeout, saturation and reset sequences.
module tb_pipeline_hazard_ctrl;

  localparam int REGW = 16;
  localparam int CNTW = 4;

  logic            CLK = 1'b0;
  logic            Reset;
  logic [REGW-1:0] id_rs1, id_rs2, ex_rd;
  logic            id_uses_rs2, ex_memread, ex_br_taken, mem_req, mem_ack;
  logic            pc_we, ifid_we, ifid_clr, idex_we, idex_clr, exmem_we;
  logic [CNTW-1:0] stall_count;
  logic            mem_err;

  int n_cmp = 0;
  int n_bad = 0;

  // {pc_we, ifid_we, ifid_clr, idex_we, idex_clr, exmem_we}
  localparam logic [5:0] O_NONE = 6'b110101;
  localparam logic [5:0] O_LU   = 6'b000111;
  localparam logic [5:0] O_BR   = 6'b111111;
  localparam logic [5:0] O_FRZ  = 6'b000000;

  logic [5:0] outs;
  assign outs = {pc_we, ifid_we, ifid_clr, idex_we, idex_clr, exmem_we};

  pipeline_hazard_ctrl #(.REGW(REGW), .MEM_TIMEOUT(8), .CNTW(CNTW)) dut (
    .CLK(CLK), .Reset(Reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_clr(ifid_clr),
    .idex_we(idex_we), .idex_clr(idex_clr), .exmem_we(exmem_we),
    .stall_count(stall_count), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string           name;
    logic [REGW-1:0] rs1, rs2;
    logic            uses;
    logic [REGW-1:0] rd;
    logic            memread, br, req, ack;
    logic [5:0]      exp_out;
    logic [CNTW-1:0] exp_cnt;   // stall_count after the edge
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [REGW-1:0] rs1, rs2, input logic uses,
                        input logic [REGW-1:0] rd, input logic memread, br, req, ack);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = uses; ex_rd = rd;
    ex_memread = memread; ex_br_taken = br; mem_req = req; mem_ack = ack;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{"none",        1, 2, 1, 7, 0, 0, 0, 0, O_NONE, 0};
    tv[1] = '{"lu_rs1",      3, 4, 0, 3, 1, 0, 0, 0, O_LU,   1};
    tv[2] = '{"lu_resolved", 3, 4, 0, 3, 0, 0, 0, 0, O_NONE, 1};
    tv[3] = '{"rd_x0",       0, 0, 1, 0, 1, 0, 0, 0, O_NONE, 1};
    tv[4] = '{"rs2_unused",  1, 5, 0, 5, 1, 0, 0, 0, O_NONE, 1};
    tv[5] = '{"lu_rs2",      1, 5, 1, 5, 1, 0, 0, 0, O_LU,   2};
    tv[6] = '{"br_beats_lu", 3, 0, 0, 3, 1, 1, 0, 0, O_BR,   2};
    tv[7] = '{"br_only",     0, 0, 0, 9, 0, 1, 0, 0, O_BR,   2};
    tv[8] = '{"load_nomatch",2, 6, 1, 4, 1, 0, 0, 0, O_NONE, 2};
    tv[9] = '{"req_acked",   1, 2, 0, 3, 0, 0, 1, 1, O_NONE, 2};

    // reset state
    Reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_outs", 32'(outs), 32'(O_FRZ));
    chk("rst_cnt", 32'(stall_count), 0);
    chk("rst_err", 32'(mem_err), 0);
    tick();
    chk("rst_hold_outs", 32'(outs), 32'(O_FRZ));
    Reset = 1'b0;
    #1;
    chk("run_outs", 32'(outs), 32'(O_NONE));

    // single-cycle RUN vectors
    for (int i = 0; i < 10; i++) begin
      set_in(tv[i].rs1, tv[i].rs2, tv[i].uses, tv[i].rd,
             tv[i].memread, tv[i].br, tv[i].req, tv[i].ack);
      #1;
      chk({tv[i].name, "_outs"}, 32'(outs), 32'(tv[i].exp_out));
      tick();
      chk({tv[i].name, "_cnt"}, 32'(stall_count), 32'(tv[i].exp_cnt));
    end

    // memory wait: 4 frozen cycles, branch/load-use ignored while frozen, then ack
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) set_in(3, 0, 0, 3, 1, 1, 1, 0);
      #1;
      chk($sformatf("mw_freeze%0d", i), 32'(outs), 32'(O_FRZ));
      tick();
    end
    chk("mw_cnt", 32'(stall_count), 6);
    set_in(0, 0, 0, 0, 0, 0, 1, 1);
    #1;
    chk("mw_ack_outs", 32'(outs), 32'(O_NONE));
    tick();
    chk("mw_ack_cnt", 32'(stall_count), 6);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("mw_back_run", 32'(outs), 32'(O_NONE));
    tick();

    // reset in the middle of a wait abandons it
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    tick();
    Reset = 1'b1;
    #1;
    chk("rst_mw_outs", 32'(outs), 32'(O_FRZ));
    chk("rst_mw_cnt", 32'(stall_count), 0);
    Reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_mw_run", 32'(outs), 32'(O_NONE));
    tick();
    chk("rst_mw_cnt2", 32'(stall_count), 0);

    // timeout: error raised on the 9th frozen edge (RUN entry + 8 waits)
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) tick();
    chk("tmo_err_early", 32'(mem_err), 0);
    chk("tmo_outs_wait", 32'(outs), 32'(O_FRZ));
    tick();
    chk("tmo_err", 32'(mem_err), 1);
    chk("tmo_cnt", 32'(stall_count), 9);
    set_in(0, 0, 0, 0, 0, 0, 1, 1);
    #1;
    chk("err_ack_frozen", 32'(outs), 32'(O_FRZ));
    for (int i = 0; i < 10; i++) tick();
    chk("cnt_saturated", 32'(stall_count), 15);
    chk("err_sticky", 32'(mem_err), 1);
    chk("err_outs", 32'(outs), 32'(O_FRZ));

    // asynchronous reset mid-cycle clears ERR immediately
    #2;
    Reset = 1'b1;
    #1;
    chk("async_rst_outs", 32'(outs), 32'(O_FRZ));
    chk("async_rst_err", 32'(mem_err), 0);
    chk("async_rst_cnt", 32'(stall_count), 0);
    Reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("post_rst_run", 32'(outs), 32'(O_NONE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
